// File: rtl/gate_pkg.sv
// Shared types and the single-bit gate evaluator for the gate_logic_unit family.
package gate_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'b000,
    OP_OR     = 3'b001,
    OP_XOR    = 3'b010,
    OP_NAND   = 3'b011,
    OP_NOR    = 3'b100,
    OP_XNOR   = 3'b101,
    OP_PASS_A = 3'b110,
    OP_NOT_A  = 3'b111
  } gate_op_e;

  localparam int RED_OR  = 0;
  localparam int RED_AND = 1;
  localparam int RED_XOR = 2;

  // Evaluated per bit so any operand width reuses the same function.
  function automatic logic gate_eval(gate_op_e op, logic a, logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XNOR:   r = ~(a ^ b);
      OP_PASS_A: r = a;
      OP_NOT_A:  r = ~a;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_logic_unit_if.sv
// Valid/ready bundle between an upstream source, gate_logic_unit and its downstream sink.
interface gate_logic_unit_if
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  gate_op_e         OP_i;
  logic             VALID_i;
  logic             READY_o;
  logic [WIDTH-1:0] F_o;
  logic             RED_o;
  logic             VALID_o;
  logic             READY_i;

  modport master (
    output A_i, B_i, OP_i, VALID_i, READY_i,
    input  READY_o, F_o, RED_o, VALID_o
  );

  modport slave (
    input  A_i, B_i, OP_i, VALID_i, READY_i,
    output READY_o, F_o, RED_o, VALID_o
  );

endinterface

// File: rtl/gate_skid_buf.sv
// One-entry skid buffer in front of an output register; full throughput, registered ready.
module gate_skid_buf #(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
);

  logic [DW-1:0] oreg_q, oreg_d;
  logic          oval_q, oval_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          skid_full_q, skid_full_d;
  logic          accept;
  logic          oreg_free;

  assign in_ready_o  = ~skid_full_q;
  assign accept      = in_valid_i & in_ready_o;
  assign oreg_free   = ~oval_q | out_ready_i;
  assign out_data_o  = oreg_q;
  assign out_valid_o = oval_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path infers a latch.
    oreg_d      = oreg_q;
    oval_d      = oval_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (oreg_free) begin
      if (skid_full_q) begin
        // The older beat in the skid always wins the register to keep order.
        oreg_d      = skid_q;
        oval_d      = 1'b1;
        skid_full_d = accept;
        if (accept) skid_d = in_data_i;
      end else if (accept) begin
        oreg_d = in_data_i;
        oval_d = 1'b1;
      end else begin
        oval_d = 1'b0;
      end
    end else if (accept) begin
      skid_d      = in_data_i;
      skid_full_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg_q      <= '0;
      oval_q      <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      oreg_q      <= oreg_d;
      oval_q      <= oval_d;
      skid_full_q <= skid_full_d;
    end
  end

  // NOTE: the skid payload is not reset; skid_full_q qualifies it, so stale data is never used.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: rtl/gate_logic_unit.sv
// Registered bitwise gate stage: eight ops on two WIDTH-bit operands plus a reduction flag.
module gate_logic_unit
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int RED_OP = RED_OR
) (
  input logic         CLK_i,
  input logic         RSTN_i,
  gate_logic_unit_if.slave bus
);

  localparam int DW = WIDTH + 1;

  logic [WIDTH-1:0] f_c;
  logic             red_c;
  logic [DW-1:0]    out_data;

  always_comb begin
    f_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f_c[i] = gate_eval(bus.OP_i, bus.A_i[i], bus.B_i[i]);
    end
  end

  // Reduction is taken before the register so RED_o always travels with its own F_o.
  always_comb begin
    red_c = 1'b0;
    case (RED_OP)
      RED_AND: red_c = &f_c;
      RED_XOR: red_c = ^f_c;
      default: red_c = |f_c;
    endcase
  end

  gate_skid_buf #(
    .DW(DW)
  ) u_skid (
    .clk        (CLK_i),
    .rst_n      (RSTN_i),
    .in_data_i  ({red_c, f_c}),
    .in_valid_i (bus.VALID_i),
    .in_ready_o (bus.READY_o),
    .out_data_o (out_data),
    .out_valid_o(bus.VALID_o),
    .out_ready_i(bus.READY_i)
  );

  assign bus.F_o   = out_data[WIDTH-1:0];
  assign bus.RED_o = out_data[WIDTH];

endmodule

// File: tb/tb_gate_logic_unit.sv
// Self-checking bench: directed cases plus randomized traffic against a truth-table/queue model.
module tb_gate_logic_unit;
  import gate_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_logic_unit_if #(.WIDTH(8)) bm ();
  gate_logic_unit_if #(.WIDTH(4)) b4 ();
  gate_logic_unit_if #(.WIDTH(1)) b1 ();
  gate_logic_unit_if #(.WIDTH(8)) br ();

  gate_logic_unit #(.WIDTH(8), .RED_OP(RED_OR))  u_main (.CLK_i(clk), .RSTN_i(rst_n), .bus(bm));
  gate_logic_unit #(.WIDTH(4), .RED_OP(RED_XOR)) u_w4   (.CLK_i(clk), .RSTN_i(rst_n), .bus(b4));
  gate_logic_unit #(.WIDTH(1), .RED_OP(RED_OR))  u_w1   (.CLK_i(clk), .RSTN_i(rst_n), .bus(b1));
  gate_logic_unit #(.WIDTH(8), .RED_OP(RED_AND)) u_rand (.CLK_i(clk), .RSTN_i(rst_n), .bus(br));

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Two-input truth tables indexed by {a,b}, one per op code.
  logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100, 4'b0011};

  function automatic logic [7:0] ref_f(logic [2:0] op, logic [7:0] a, logic [7:0] b, int w);
    logic [7:0] r;
    logic [3:0] row;
    r   = '0;
    row = tt[op];
    for (int i = 0; i < w; i++) r[i] = row[{a[i], b[i]}];
    return r;
  endfunction

  function automatic logic ref_red(logic [7:0] f, int w, int red);
    int cnt;
    cnt = 0;
    for (int i = 0; i < w; i++) cnt += int'(f[i]);
    if (red == RED_AND) return cnt == w;
    if (red == RED_XOR) return cnt % 2 == 1;
    return cnt > 0;
  endfunction

  // Scoreboard for the main instance: beats accepted but not yet delivered, oldest first.
  logic [8:0] q [$];
  int  n_acc = 0;
  int  n_xfer = 0;
  bit  main_acc = 0;

  task automatic mon_main();
    logic [8:0] e;
    logic [7:0] f;
    main_acc = 0;
    if (!rst_n) begin
      check("rst_valid", 32'(bm.VALID_o), 32'd0);
      check("rst_ready", 32'(bm.READY_o), 32'd1);
      check("rst_f",     32'(bm.F_o),     32'd0);
    end else begin
      check("m_ready", 32'(bm.READY_o), 32'(q.size() < 2));
      check("m_valid", 32'(bm.VALID_o), 32'(q.size() > 0));
      if (bm.VALID_o && bm.READY_i && q.size() > 0) begin
        e = q.pop_front();
        check("m_f",   32'(bm.F_o),   32'(e[7:0]));
        check("m_red", 32'(bm.RED_o), 32'(e[8]));
        n_xfer++;
      end
      if (bm.VALID_i && bm.READY_o) begin
        f = ref_f(bm.OP_i, bm.A_i, bm.B_i, 8);
        q.push_back({ref_red(f, 8, RED_OR), f});
        n_acc++;
        main_acc = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_main();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bm.VALID_i = 1'b0;
    bm.READY_i = 1'b1;
    for (int i = 0; i < 8 && (q.size() > 0 || bm.VALID_o); i++) tick();
    check("drain", 32'(q.size()), 32'd0);
  endtask

  logic [3:0] t1_f   [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100, 4'b0011};
  logic       t1_red [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic       t2_a   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       t2_b   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       t2_f   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    logic [7:0] ef;
    bm.A_i = '0; bm.B_i = '0; bm.OP_i = OP_AND; bm.VALID_i = 1'b0; bm.READY_i = 1'b1;
    b4.A_i = '0; b4.B_i = '0; b4.OP_i = OP_AND; b4.VALID_i = 1'b0; b4.READY_i = 1'b1;
    b1.A_i = '0; b1.B_i = '0; b1.OP_i = OP_AND; b1.VALID_i = 1'b0; b1.READY_i = 1'b1;
    br.A_i = '0; br.B_i = '0; br.OP_i = OP_AND; br.VALID_i = 1'b0; br.READY_i = 1'b1;

    #2;
    check("reset_valid", 32'(bm.VALID_o), 32'd0);
    check("reset_f",     32'(bm.F_o),     32'd0);
    check("reset_red",   32'(bm.RED_o),   32'd0);
    check("reset_ready", 32'(bm.READY_o), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;

    // Eight ops on a 4-bit instance, one result per cycle.
    for (int op = 0; op < 8; op++) begin
      b4.A_i = 4'b1100; b4.B_i = 4'b1010; b4.OP_i = gate_op_e'(3'(op)); b4.VALID_i = 1'b1;
      tick();
      check("t1_f",     32'(b4.F_o),     32'(t1_f[op]));
      check("t1_red",   32'(b4.RED_o),   32'(t1_red[op]));
      check("t1_valid", 32'(b4.VALID_o), 32'd1);
    end
    b4.VALID_i = 1'b0;

    // Legacy OR table on a 1-bit instance.
    for (int k = 0; k < 4; k++) begin
      b1.A_i = t2_a[k]; b1.B_i = t2_b[k]; b1.OP_i = OP_OR; b1.VALID_i = 1'b1;
      tick();
      check("t2_f",   32'(b1.F_o),   32'(t2_f[k]));
      check("t2_red", 32'(b1.RED_o), 32'(t2_f[k]));
    end
    b1.VALID_i = 1'b0;

    // Reduction flags: OR-reduce of AND result, AND-reduce of OR result.
    bm.A_i = 8'h0F; bm.B_i = 8'hF0; bm.OP_i = OP_AND; bm.VALID_i = 1'b1;
    br.A_i = 8'h0F; br.B_i = 8'hF0; br.OP_i = OP_OR;  br.VALID_i = 1'b1;
    tick();
    check("t5_or_f",    32'(bm.F_o),   32'h00);
    check("t5_or_red",  32'(bm.RED_o), 32'd0);
    check("t5_and_f",   32'(br.F_o),   32'hFF);
    check("t5_and_red", 32'(br.RED_o), 32'd1);
    br.VALID_i = 1'b0;
    drain();

    // Back-to-back XOR beats at full rate.
    x0 = n_xfer;
    for (int i = 0; i < 16; i++) begin
      bm.A_i = 8'(i); bm.B_i = ~8'(i); bm.OP_i = OP_XOR; bm.VALID_i = 1'b1;
      tick();
      check("b2b_f",     32'(bm.F_o),     32'hFF);
      check("b2b_ready", 32'(bm.READY_o), 32'd1);
    end
    bm.VALID_i = 1'b0;
    tick();
    check("b2b_count", 32'(n_xfer - x0), 32'd16);
    drain();

    // Backpressure: X1 in OREG, X2 in skid, X3 stalls until the output drains.
    bm.READY_i = 1'b0;
    bm.A_i = 8'h3C; bm.B_i = 8'h0F; bm.OP_i = OP_AND; bm.VALID_i = 1'b1;
    tick();
    check("bp_x1", 32'(bm.F_o), 32'h0C);
    bm.A_i = 8'h55; bm.B_i = 8'hAA; bm.OP_i = OP_OR;
    tick();
    check("bp_ready_low", 32'(bm.READY_o), 32'd0);
    check("bp_hold",      32'(bm.F_o),     32'h0C);
    bm.A_i = 8'hF0; bm.B_i = 8'h00; bm.OP_i = OP_NOT_A;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stall", 32'(main_acc), 32'd0);
      check("bp_hold",  32'(bm.F_o),   32'h0C);
      check("bp_valid", 32'(bm.VALID_o), 32'd1);
    end
    bm.READY_i = 1'b1;
    x0 = n_xfer;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (main_acc) bm.VALID_i = 1'b0;
    end
    check("bp_drain", 32'(n_xfer - x0), 32'd3);
    drain();

    // Random traffic with random backpressure; the upstream holds a beat until taken.
    bm.VALID_i = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!bm.VALID_i || main_acc) begin
        bm.VALID_i = ($urandom_range(0, 3) != 0);
        bm.A_i     = 8'($urandom);
        bm.B_i     = 8'($urandom);
        bm.OP_i    = gate_op_e'(3'($urandom_range(0, 7)));
      end
      bm.READY_i = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();
    check("acc_eq_xfer", 32'(n_xfer), 32'(n_acc));

    // Random ops on the 4-bit XOR-reduce and 8-bit AND-reduce instances.
    for (int c = 0; c < 30; c++) begin
      b4.A_i = 4'($urandom); b4.B_i = 4'($urandom);
      b4.OP_i = gate_op_e'(3'($urandom_range(0, 7))); b4.VALID_i = 1'b1;
      br.A_i = 8'($urandom); br.B_i = 8'($urandom);
      br.OP_i = gate_op_e'(3'($urandom_range(0, 7))); br.VALID_i = 1'b1;
      tick();
      ef = ref_f(b4.OP_i, 8'(b4.A_i), 8'(b4.B_i), 4);
      check("w4_f",   32'(b4.F_o),   32'(ef[3:0]));
      check("w4_red", 32'(b4.RED_o), 32'(ref_red(ef, 4, RED_XOR)));
      ef = ref_f(br.OP_i, br.A_i, br.B_i, 8);
      check("and_f",   32'(br.F_o),   32'(ef));
      check("and_red", 32'(br.RED_o), 32'(ref_red(ef, 8, RED_AND)));
    end
    b4.VALID_i = 1'b0;
    br.VALID_i = 1'b0;

    // Reset mid-cycle with both entries occupied.
    bm.READY_i = 1'b0;
    bm.A_i = 8'h12; bm.B_i = 8'h34; bm.OP_i = OP_XOR; bm.VALID_i = 1'b1;
    tick();
    bm.A_i = 8'h9A; bm.B_i = 8'hFF; bm.OP_i = OP_NAND;
    tick();
    bm.A_i = 8'hA5; bm.B_i = 8'h0F; bm.OP_i = OP_XNOR;
    check("r6_full",  32'(bm.READY_o), 32'd0);
    check("r6_valid", 32'(bm.VALID_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("r6_valid_rst", 32'(bm.VALID_o), 32'd0);
    check("r6_f_rst",     32'(bm.F_o),     32'd0);
    check("r6_red_rst",   32'(bm.RED_o),   32'd0);
    check("r6_ready_rst", 32'(bm.READY_o), 32'd1);
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    bm.READY_i = 1'b1;
    tick();
    check("r6_after_f",     32'(bm.F_o),     32'h55);
    check("r6_after_valid", 32'(bm.VALID_o), 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
